// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader.
// Optional checksum feature is selected with INSTR_LOADER_CHECKSUM_EN.
package instr_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } il_state_e;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word packer: 32-bit shift register plus byte counter,
// zero-filling the low-order bytes when the stream ends mid-word.
module byte_packer
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_push,
  input  logic [7:0]  i_data,
  input  logic        i_last,
  output logic [31:0] o_word,
  output logic        o_word_done
);

  logic [31:0] r_shift;
  logic [1:0]  r_cnt;
  logic [31:0] w_packed;

  // On the last byte, shift the partial word up so unfilled bytes become zero
  // and stale bytes from the previous word fall off the top.
  always_comb begin
    w_packed = {r_shift[23:0], i_data};
    if (i_last) begin
      case (r_cnt)
        2'd0:    w_packed = {i_data, 24'h0};
        2'd1:    w_packed = {r_shift[7:0], i_data, 16'h0};
        2'd2:    w_packed = {r_shift[15:0], i_data, 8'h0};
        default: w_packed = {r_shift[23:0], i_data};
      endcase
    end
  end

  assign o_word_done = i_push && (i_last || (r_cnt == 2'(BYTES_PER_WORD - 1)));
  assign o_word      = r_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_push) begin
      r_shift <= w_packed;
      r_cnt   <= i_last ? 2'd0 : r_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Streams program bytes into instruction memory, holding the CPU in reset
// until the load completes. Define INSTR_LOADER_CHECKSUM_EN for sum checking.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic              clk_il,
  input  logic              rst_n_il,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst_n
);

  // Word index needs one extra value beyond the last word to flag overflow.
  localparam int unsigned      IDX_W   = ADDR_W - 1;
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MEM_BYTES / BYTES_PER_WORD);

  il_state_e        r_state;
  il_state_e        w_next;
  logic [IDX_W-1:0] r_word_idx;
  logic             r_last_word;
  logic             r_err;
  logic             w_xfer;
  logic             w_ovf;
  logic             w_start_load;
  logic             w_word_done;
  logic [31:0]      w_word;

  assign w_xfer       = byte_valid && byte_ready;
  assign w_ovf        = w_xfer && (r_word_idx == MAX_IDX);
  assign w_start_load = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  byte_packer u_packer (
    .clk         (clk_il),
    .rst_n       (rst_n_il),
    .i_clear     (w_start_load),
    .i_push      (w_xfer && !w_ovf),
    .i_data      (byte_data),
    .i_last      (byte_last),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

  always_ff @(posedge clk_il or negedge rst_n_il) begin
    if (!rst_n_il) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_LOAD;
      ST_LOAD: begin
        if (w_ovf)            w_next = ST_DONE;
        else if (w_word_done) w_next = ST_WRITE;
      end
      ST_WRITE: w_next = r_last_word ? ST_DONE : ST_LOAD;
      ST_DONE:  if (start) w_next = ST_LOAD;
      default:  w_next = ST_IDLE;
    endcase
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;

  always_ff @(posedge clk_il or negedge rst_n_il) begin
    if (!rst_n_il)        r_sum <= '0;
    else if (w_start_load) r_sum <= '0;
    else if (w_xfer)       r_sum <= r_sum + byte_data;
  end
`endif

  always_ff @(posedge clk_il or negedge rst_n_il) begin
    if (!rst_n_il) begin
      r_word_idx  <= '0;
      r_last_word <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_start_load) begin
      r_word_idx  <= '0;
      r_last_word <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_ovf) r_err <= 1'b1;
      if ((r_state == ST_LOAD) && w_word_done) r_last_word <= byte_last;
      if ((r_state == ST_WRITE) && !r_last_word) r_word_idx <= r_word_idx + 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
      // Sum already includes the final byte by the time WRITE is reached.
      if ((r_state == ST_WRITE) && r_last_word && (r_sum != 8'h00)) r_err <= 1'b1;
`endif
    end
  end

  always_comb begin
    byte_ready = (r_state == ST_LOAD);
    busy       = (r_state == ST_LOAD) || (r_state == ST_WRITE);
    mem_we     = (r_state == ST_WRITE);
    mem_addr   = '0;
    mem_wdata  = '0;
    if (r_state == ST_WRITE) begin
      mem_addr  = {r_word_idx[ADDR_W-3:0], 2'b00};
      mem_wdata = w_word;
    end
    done = (r_state == ST_DONE);
    err  = r_err;
`ifdef INSTR_LOADER_CHECKSUM_EN
    cpu_rst_n = (r_state == ST_DONE) && !r_err;
`else
    cpu_rst_n = (r_state == ST_DONE);
`endif
  end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: a default-size instance and an 8-byte instance share
// one byte stream and are checked against a byte-list reference model.
module tb_instr_loader;

`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic bv = 1'b0;
  logic [7:0] bd = 8'h00;
  logic bl = 1'b0;

  logic b_ready, b_we, b_busy, b_done, b_err, b_cpu;
  logic [7:0] b_addr;
  logic [31:0] b_wdata;
  logic s_ready, s_we, s_busy, s_done, s_err, s_cpu;
  logic [2:0] s_addr;
  logic [31:0] s_wdata;

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [7:0]  prog[$];
  logic [7:0]  bq_addr[$];
  logic [31:0] bq_data[$];
  logic        bq_rdy[$];
  logic [7:0]  sq_addr[$];
  logic [31:0] sq_data[$];

  instr_loader #(.MEM_BYTES(256), .ADDR_W(8)) u_big (
    .clk_il(clk), .rst_n_il(rst_n), .start(start), .byte_valid(bv),
    .byte_data(bd), .byte_last(bl), .byte_ready(b_ready), .mem_we(b_we),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .busy(b_busy), .done(b_done),
    .err(b_err), .cpu_rst_n(b_cpu)
  );

  instr_loader #(.MEM_BYTES(8), .ADDR_W(3)) u_small (
    .clk_il(clk), .rst_n_il(rst_n), .start(start), .byte_valid(bv),
    .byte_data(bd), .byte_last(bl), .byte_ready(s_ready), .mem_we(s_we),
    .mem_addr(s_addr), .mem_wdata(s_wdata), .busy(s_busy), .done(s_done),
    .err(s_err), .cpu_rst_n(s_cpu)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (b_we) begin
      bq_addr.push_back(b_addr);
      bq_data.push_back(b_wdata);
      bq_rdy.push_back(b_ready);
    end
    if (s_we) begin
      sq_addr.push_back({5'd0, s_addr});
      sq_data.push_back(s_wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int unsigned exp_nwr(input int unsigned mem);
    int unsigned n = prog.size();
    return (n > mem) ? mem / 4 : (n + 3) / 4;
  endfunction

  function automatic logic [31:0] exp_word(input int unsigned w);
    logic [31:0] v = 32'h0;
    for (int unsigned k = 0; k < 4; k++) begin
      int unsigned j = 4 * w + k;
      if (j < prog.size()) v = v | ({24'h0, prog[j]} << (24 - 8 * k));
    end
    return v;
  endfunction

  function automatic logic exp_err(input int unsigned mem);
    int unsigned sum = 0;
    foreach (prog[i]) sum = sum + prog[i];
    return (prog.size() > mem) || (CK && ((sum % 256) != 0));
  endfunction

  function automatic logic exp_cpu(input int unsigned mem);
    return CK ? !exp_err(mem) : 1'b1;
  endfunction

  // ---------------- stimulus ----------------
  task automatic clear_mon;
    bq_addr.delete(); bq_data.delete(); bq_rdy.delete();
    sq_addr.delete(); sq_data.delete();
  endtask

  task automatic do_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l,
                           input int unsigned gap, input bit poke);
    int unsigned waited = 0;
    repeat (gap) begin @(posedge clk); #1; end
    bv = 1'b1; bd = d; bl = l;
    start = poke && ($urandom_range(0, 2) == 0);
    @(negedge clk);
    while (!b_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!b_ready) begin
      total++; bad++;
      $display("FAIL byte_ready_timeout: ready=%0b required=1", b_ready);
    end
    @(posedge clk); #1;
    bv = 1'b0; bl = 1'b0; start = 1'b0;
  endtask

  task automatic wait_done;
    int unsigned waited = 0;
    @(negedge clk);
    while (!b_done && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!b_done) begin
      total++; bad++;
      $display("FAIL done_timeout: done=%0b required=1", b_done);
    end
  endtask

  task automatic run_prog(input int unsigned gap_max, input bit poke);
    clear_mon();
    do_start();
    foreach (prog[i])
      send_byte(prog[i], i == prog.size() - 1, $urandom_range(0, gap_max), poke);
    wait_done();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #3;
    total++;
    if ({b_ready, b_we, b_addr, b_wdata, b_busy, b_done, b_err, b_cpu} !== '0) begin
      bad++;
      $display("FAIL reset_big: outputs=%h required=0",
               {b_ready, b_we, b_addr, b_wdata, b_busy, b_done, b_err, b_cpu});
    end
    total++;
    if ({s_ready, s_we, s_addr, s_wdata, s_busy, s_done, s_err, s_cpu} !== '0) begin
      bad++;
      $display("FAIL reset_small: outputs=%h required=0",
               {s_ready, s_we, s_addr, s_wdata, s_busy, s_done, s_err, s_cpu});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({b_cpu, b_ready, b_busy, b_done} !== 4'b0000) begin
      bad++;
      $display("FAIL idle_hold: cpu/ready/busy/done=%b required=0000",
               {b_cpu, b_ready, b_busy, b_done});
    end
  endtask

  task automatic test_single_word;
    prog = '{8'h20, 8'h08, 8'h00, 8'h05};
    clear_mon();
    do_start();
    total++;
    if ({b_busy, b_done, b_cpu} !== 3'b100) begin
      bad++;
      $display("FAIL start_busy: busy/done/cpu=%b required=100", {b_busy, b_done, b_cpu});
    end
    for (int i = 0; i < 3; i++) send_byte(prog[i], 1'b0, 0, 1'b0);
    send_byte(prog[3], 1'b1, 0, 1'b0);
    total++;
    if ({b_we, b_addr, b_wdata} !== {1'b1, 8'h00, 32'h20080005}) begin
      bad++;
      $display("FAIL write_latency: we=%0b addr=%h data=%h required we=1 addr=00 data=20080005",
               b_we, b_addr, b_wdata);
    end
    wait_done();
    total++;
    if (bq_data.size() != 1) begin
      bad++;
      $display("FAIL single_count: writes=%0d required=1", bq_data.size());
    end
    total++;
    if ({b_done, b_err, b_cpu} !== {1'b1, exp_err(256), exp_cpu(256)}) begin
      bad++;
      $display("FAIL single_done: done/err/cpu=%b required=%b",
               {b_done, b_err, b_cpu}, {1'b1, exp_err(256), exp_cpu(256)});
    end
  endtask

  task automatic test_gapped;
    prog.delete();
    for (int i = 0; i < 8; i++) prog.push_back(8'($urandom));
    clear_mon();
    do_start();
    foreach (prog[i]) send_byte(prog[i], i == 7, 1, 1'b0);
    wait_done();
    total++;
    if (bq_data.size() != 2) begin
      bad++;
      $display("FAIL gapped_count: writes=%0d required=2", bq_data.size());
    end else begin
      for (int w = 0; w < 2; w++) begin
        total++;
        if ({bq_addr[w], bq_data[w], bq_rdy[w]} !== {8'(4 * w), exp_word(w), 1'b0}) begin
          bad++;
          $display("FAIL gapped_write%0d: addr=%h data=%h ready=%0b required addr=%h data=%h ready=0",
                   w, bq_addr[w], bq_data[w], bq_rdy[w], 8'(4 * w), exp_word(w));
        end
      end
    end
  endtask

  task automatic test_partial;
    prog = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    run_prog(0, 1'b0);
    total++;
    if (bq_data.size() != 2) begin
      bad++;
      $display("FAIL partial_count: writes=%0d required=2", bq_data.size());
    end else begin
      total++;
      if ({bq_addr[1], bq_data[1]} !== {8'h04, 32'h11220000}) begin
        bad++;
        $display("FAIL partial_pad: addr=%h data=%h required addr=04 data=11220000",
                 bq_addr[1], bq_data[1]);
      end
    end
  endtask

  task automatic test_overflow;
    prog = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    run_prog(0, 1'b0);
    total++;
    if ({sq_data.size() == 2, s_err, s_done} !== 3'b111) begin
      bad++;
      $display("FAIL overflow_small: writes=%0d err=%0b done=%0b required writes=2 err=1 done=1",
               sq_data.size(), s_err, s_done);
    end
    total++;
    if (bq_data.size() != 3) begin
      bad++;
      $display("FAIL overflow_big_count: writes=%0d required=3", bq_data.size());
    end else if ({bq_addr[2], bq_data[2], b_err} !== {8'h08, 32'h09000000, exp_err(256)}) begin
      bad++;
      $display("FAIL overflow_big: addr=%h data=%h err=%0b required addr=08 data=09000000 err=%0b",
               bq_addr[2], bq_data[2], b_err, exp_err(256));
    end
  endtask

  task automatic test_reset_midword;
    clear_mon();
    do_start();
    send_byte(8'h5A, 1'b0, 0, 1'b0);
    send_byte(8'hA5, 1'b0, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({b_ready, b_we, b_addr, b_wdata, b_busy, b_done, b_err, b_cpu,
         s_ready, s_busy, s_cpu} !== '0) begin
      bad++;
      $display("FAIL midword_reset: big=%h small_ready/busy/cpu=%b required 0",
               {b_ready, b_we, b_addr, b_wdata, b_busy, b_done, b_err, b_cpu},
               {s_ready, s_busy, s_cpu});
    end
    @(negedge clk); rst_n = 1'b1;
    prog = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_prog(0, 1'b0);
    total++;
    if (bq_data.size() < 1) begin
      bad++;
      $display("FAIL midword_reload: writes=0 required=1");
    end else if ({bq_addr[0], bq_data[0]} !== {8'h00, 32'h12345678}) begin
      bad++;
      $display("FAIL midword_reload: addr=%h data=%h required addr=00 data=12345678",
               bq_addr[0], bq_data[0]);
    end
  endtask

  task automatic test_random;
    for (int t = 0; t < 8; t++) begin
      int unsigned n = $urandom_range(1, 14);
      prog.delete();
      for (int unsigned i = 0; i < n; i++) prog.push_back(8'($urandom));
      run_prog(2, n <= 8);
      total++;
      if (bq_data.size() != exp_nwr(256) || sq_data.size() != exp_nwr(8)) begin
        bad++;
        $display("FAIL rand%0d_count: big=%0d small=%0d required big=%0d small=%0d",
                 t, bq_data.size(), sq_data.size(), exp_nwr(256), exp_nwr(8));
      end else begin
        foreach (bq_data[w]) begin
          total++;
          if ({bq_addr[w], bq_data[w], bq_rdy[w]} !== {8'(4 * w), exp_word(w), 1'b0}) begin
            bad++;
            $display("FAIL rand%0d_big_w%0d: addr=%h data=%h ready=%0b required addr=%h data=%h ready=0",
                     t, w, bq_addr[w], bq_data[w], bq_rdy[w], 8'(4 * w), exp_word(w));
          end
        end
        foreach (sq_data[w]) begin
          total++;
          if ({sq_addr[w], sq_data[w]} !== {8'(4 * w), exp_word(w)}) begin
            bad++;
            $display("FAIL rand%0d_small_w%0d: addr=%h data=%h required addr=%h data=%h",
                     t, w, sq_addr[w], sq_data[w], 8'(4 * w), exp_word(w));
          end
        end
      end
      total++;
      if ({b_done, b_err, b_cpu, s_done, s_err, s_cpu} !==
          {1'b1, exp_err(256), exp_cpu(256), 1'b1, exp_err(8), exp_cpu(8)}) begin
        bad++;
        $display("FAIL rand%0d_status: big done/err/cpu=%b small=%b required %b %b", t,
                 {b_done, b_err, b_cpu}, {s_done, s_err, s_cpu},
                 {1'b1, exp_err(256), exp_cpu(256)}, {1'b1, exp_err(8), exp_cpu(8)});
      end
    end
  endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    prog = '{8'h01, 8'h02, 8'h03, 8'hFA};
    run_prog(0, 1'b0);
    total++;
    if ({b_err, b_cpu} !== 2'b01) begin
      bad++;
      $display("FAIL checksum_good: err/cpu=%b required=01", {b_err, b_cpu});
    end
    prog = '{8'h01, 8'h02, 8'h03, 8'hFB};
    run_prog(0, 1'b0);
    total++;
    if ({b_err, b_cpu} !== 2'b10) begin
      bad++;
      $display("FAIL checksum_bad: err/cpu=%b required=10", {b_err, b_cpu});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_gapped();
    test_partial();
    test_overflow();
    test_reset_midword();
    test_random();
`ifdef INSTR_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
